blake_g_seq: RTL and testbench

Iterative BLAKE-256 G-function sequencer that time-shares one carry-save adder (3:2 compressor) plus one 32-bit carry-propagate adder across the eight mixing steps of G. It accepts a 4-word state column/diagonal and two pre-XORed message/constant words over a valid/ready handshake. It runs the eight steps on consecutive cycles and presents the mixed words on a held output handshake. It sits between the round controller and the shared add unit in area-constrained miner variants.

---
 rtl/blake_pkg.sv | 30 +++
 rtl/blake_add3.sv | 21 ++
 rtl/blake_g_seq.sv | 119 +++++++++++
 tb/tb_blake_g_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/blake_pkg.sv
// Shared types and constants for the BLAKE-256 G-function sequencer.
// Holds the step-state encoding, the word width and the default rotate amounts.
package blake_pkg;

  localparam int WORD_W = 32;

  localparam int unsigned ROT0_DEF = 16;
  localparam int unsigned ROT1_DEF = 12;
  localparam int unsigned ROT2_DEF = 8;
  localparam int unsigned ROT3_DEF = 7;

  typedef enum logic [3:0] {
    IDLE,
    S0,
    S1,
    S2,
    S3,
    S4,
    S5,
    S6,
    S7,
    DONE
  } state_t;

  // Constant-amount rotate right; reduces to pure wiring.
  function automatic logic [WORD_W-1:0] ror32(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/blake_add3.sv
// Three-input modulo-2^32 adder: one 3:2 carry-save stage, then one carry-propagate add.
// The carry vector's top bit and the final carry-out fall off the word.
module blake_add3
  import blake_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] z,
  output logic [WORD_W-1:0] sum
);

  logic [WORD_W-1:0] vs;
  logic [WORD_W-1:0] vc;

  assign vs  = x ^ y ^ z;
  assign vc  = {(x[WORD_W-2:0] & y[WORD_W-2:0]) |
                (x[WORD_W-2:0] & z[WORD_W-2:0]) |
                (y[WORD_W-2:0] & z[WORD_W-2:0]), 1'b0};
  assign sum = vs + vc;

endmodule

// File: rtl/blake_g_seq.sv
// Iterative BLAKE-256 G function: eight mixing steps on consecutive cycles,
// all additions sharing a single blake_add3 instance.
module blake_g_seq
  import blake_pkg::*;
#(
  parameter int unsigned ROT0 = ROT0_DEF,
  parameter int unsigned ROT1 = ROT1_DEF,
  parameter int unsigned ROT2 = ROT2_DEF,
  parameter int unsigned ROT3 = ROT3_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] b_in,
  input  logic [WORD_W-1:0] c_in,
  input  logic [WORD_W-1:0] d_in,
  input  logic [WORD_W-1:0] mx0,
  input  logic [WORD_W-1:0] mx1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] a_out,
  output logic [WORD_W-1:0] b_out,
  output logic [WORD_W-1:0] c_out,
  output logic [WORD_W-1:0] d_out,
  output logic              busy
);

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] a_reg, b_reg, c_reg, d_reg, mx0_reg, mx1_reg;
  logic [WORD_W-1:0] add_x, add_y, add_z, add_sum;
  logic              load;

  // S2/S6 add c+d; every other add step is a+b+mx.
  always_comb begin
    add_x = a_reg;
    add_y = b_reg;
    add_z = mx0_reg;
    case (state_reg)
      S4:      add_z = mx1_reg;
      S2, S6: begin
        add_x = c_reg;
        add_y = d_reg;
        add_z = '0;
      end
      default: ;
    endcase
  end

  blake_add3 u_add3 (
    .x   (add_x),
    .y   (add_y),
    .z   (add_z),
    .sum (add_sum)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = S0;
      S0:      state_next = S1;
      S1:      state_next = S2;
      S2:      state_next = S3;
      S3:      state_next = S4;
      S4:      state_next = S5;
      S5:      state_next = S6;
      S6:      state_next = S7;
      S7:      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr) state_next = IDLE;
  end

  assign load = (state_reg == IDLE) && in_valid && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      mx0_reg   <= '0;
      mx1_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        a_reg   <= a_in;
        b_reg   <= b_in;
        c_reg   <= c_in;
        d_reg   <= d_in;
        mx0_reg <= mx0;
        mx1_reg <= mx1;
      end else if (!clr) begin
        case (state_reg)
          S0, S4: a_reg <= add_sum;
          S1:     d_reg <= ror32(d_reg ^ a_reg, ROT0);
          S2, S6: c_reg <= add_sum;
          S3:     b_reg <= ror32(b_reg ^ c_reg, ROT1);
          S5:     d_reg <= ror32(d_reg ^ a_reg, ROT2);
          S7:     b_reg <= ror32(b_reg ^ c_reg, ROT3);
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign a_out     = a_reg;
  assign b_out     = b_reg;
  assign c_out     = c_reg;
  assign d_out     = d_reg;

endmodule

// File: tb/tb_blake_g_seq.sv
// Scoreboard bench for blake_g_seq: directed vectors with hand-computed results,
// plus backpressure, clr abort and asynchronous reset mid-operation.
module tb_blake_g_seq;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } words_t;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a_in, b_in, c_in, d_in, mx0, mx1;
  logic [31:0] a_out, b_out, c_out, d_out;

  int total = 0;
  int bad   = 0;
  words_t exp_q[$];

  always #5 clk = ~clk;

  blake_g_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .d_in      (d_in),
    .mx0       (mx0),
    .mx1       (mx1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .d_out     (d_out),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Drive one request; returns just after the accepting edge.
  task automatic send(input words_t w, input logic [31:0] m0, input logic [31:0] m1,
                      input bit push, input words_t exp);
    int n = 0;
    @(negedge clk);
    a_in = w.a; b_in = w.b; c_in = w.c; d_in = w.d; mx0 = m0; mx1 = m1;
    in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        fail_now("send_in_ready");
        break;
      end
    end
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        fail_now("wait_out_valid");
        break;
      end
    end
  endtask

  task automatic wait_done();
    wait_valid();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_a_out"}, a_out, 32'd0);
    chk({tag, "_b_out"}, b_out, 32'd0);
    chk({tag, "_c_out"}, c_out, 32'd0);
    chk({tag, "_d_out"}, d_out, 32'd0);
  endtask

  // Monitor: tracks latency since acceptance and busy length, checks on out_valid rise.
  int lat_cnt = 0;
  int busy_cnt = 0;
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || in_ready) begin
      lat_cnt  = 0;
      busy_cnt = 0;
    end else begin
      lat_cnt++;
      if (busy) busy_cnt++;
    end
    if (out_valid && !prev_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid: got a=%08h b=%08h c=%08h d=%08h want none",
                 a_out, b_out, c_out, d_out);
      end else begin
        words_t e;
        e = exp_q.pop_front();
        $display("txn a=%08h b=%08h c=%08h d=%08h lat=%0d busy=%0d",
                 a_out, b_out, c_out, d_out, lat_cnt, busy_cnt);
        chk("a_out", a_out, e.a);
        chk("b_out", b_out, e.b);
        chk("c_out", c_out, e.c);
        chk("d_out", d_out, e.d);
        chk("latency", lat_cnt, 32'd9);
        chk("busy_cycles", busy_cnt, 32'd8);
      end
    end
    prev_valid = out_valid;
  end

  words_t z_w, v2_w, v3_w, v2_x, v3_x;

  initial begin
    z_w  = '{a: 32'h0,        b: 32'h0,        c: 32'h0,        d: 32'h0};
    v2_w = '{a: 32'h00000001, b: 32'h0,        c: 32'h0,        d: 32'h0};
    v2_x = '{a: 32'h00000011, b: 32'h20220202, c: 32'h11010100, d: 32'h11000100};
    v3_w = '{a: 32'hFFFFFFFF, b: 32'h00000001, c: 32'h0,        d: 32'h0};
    v3_x = '{a: 32'h00100000, b: 32'h00002020, c: 32'h00001000, d: 32'h00001000};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0; mx0 = '0; mx1 = '0;
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    send(z_w, 32'h0, 32'h0, 1'b1, z_w);
    wait_done();
    send(v2_w, 32'h0, 32'h0, 1'b1, v2_x);
    wait_done();
    send(v3_w, 32'h0, 32'h0, 1'b1, v3_x);
    wait_done();

    // Backpressure with a competing request held on the input
    out_ready = 1'b0;
    send(v2_w, 32'h0, 32'h0, 1'b1, v2_x);
    wait_valid();
    a_in = v3_w.a; b_in = v3_w.b; in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      chk("bp_a_out", a_out, v2_x.a);
      chk("bp_b_out", b_out, v2_x.b);
      chk("bp_c_out", c_out, v2_x.c);
      chk("bp_d_out", d_out, v2_x.d);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready},  32'd1);

    // clr together with in_valid in IDLE: request must not be taken
    a_in = v3_w.a; b_in = v3_w.b; in_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    chk("clr_vs_valid_busy",  {31'd0, busy},     32'd0);
    chk("clr_vs_valid_ready", {31'd0, in_ready}, 32'd1);

    // clr during S4
    send(v3_w, 32'h0, 32'h0, 1'b0, v3_x);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("clr_s4_busy", {31'd0, busy}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_idle_ready", {31'd0, in_ready},  32'd1);
    chk("clr_idle_busy",  {31'd0, busy},      32'd0);
    repeat (12) begin
      @(negedge clk);
      chk("clr_no_valid", {31'd0, out_valid}, 32'd0);
    end
    send(v2_w, 32'h0, 32'h0, 1'b1, v2_x);
    wait_done();

    // Asynchronous reset during S6
    send(v2_w, 32'h0, 32'h0, 1'b0, v2_x);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_s6");
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rel_ready", {31'd0, in_ready}, 32'd1);
    send(v3_w, 32'h0, 32'h0, 1'b1, v3_x);
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
